// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with bypass and pending-register scoreboard
//
// Purpose: architectural register file (x0 hardwired to zero) with NUM_WR write
// ports, NUM_RD combinational read ports with same-cycle write bypass, and a
// per-register pending bit set on issue and cleared on writeback.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   we_i          per-write-port enable
//   wr_addr_i     packed write addresses, port k in slice k
//   wr_data_i     packed write data, port k in slice k
//   rd_addr_i     packed read addresses, port j in slice j
//   rd_data_o     packed read data (combinational, bypassed)
//   rd_ready_o    per-read-port operand-valid flag (combinational)
//   iss_valid_i   issue strobe reserving iss_rd_i
//   iss_rd_i      destination register being reserved
//   flush_i       clear all reservations
//   busy_cnt_o    registered number of pending registers
module regfile_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter int ADDR_WIDTH = $clog2(REG_COUNT),
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_WR-1:0]              we_i,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr_i,
   input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data_i,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_i,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
   output logic [NUM_RD-1:0]              rd_ready_o,
   input  logic                           iss_valid_i,
   input  logic [ADDR_WIDTH-1:0]          iss_rd_i,
   input  logic                           flush_i,
   output logic [$clog2(REG_COUNT+1)-1:0] busy_cnt_o
);

   localparam int CW = $clog2(REG_COUNT+1);

   logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
   logic [REG_COUNT-1:0]                 pend;
   logic [REG_COUNT-1:0]                 pend_nxt;
   logic [CW-1:0]                        cnt_nxt;

   // Read ports: bypass scan goes low-to-high so the highest-index matching
   // write port ends up as the forwarded value, same as the storage update.
   always_comb begin
      rd_data_o  = '0;
      rd_ready_o = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         logic [ADDR_WIDTH-1:0] ra;
         logic                  hit;
         logic [DATA_WIDTH-1:0] byp;
         ra  = rd_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
         hit = 1'b0;
         byp = '0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && (wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
                (wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
               hit = 1'b1;
               byp = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         if (ra == '0) begin
            rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = '0;
            rd_ready_o[j]                         = 1'b1;
         end else begin
            rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = hit ? byp : regs[ra];
            rd_ready_o[j]                         = hit || !pend[ra];
         end
      end
   end

   // Scoreboard next state: flush or writeback clears, then a new issue sets,
   // so an issue always wins over a same-cycle clear of the same register.
   always_comb begin
      pend_nxt = flush_i ? '0 : pend;
      for (int k = 0; k < NUM_WR; k++) begin
         if (we_i[k]) begin
            pend_nxt[wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
         end
      end
      if (iss_valid_i) begin
         pend_nxt[iss_rd_i] = 1'b1;
      end
      pend_nxt[0] = 1'b0;
      cnt_nxt = '0;
      for (int r = 1; r < REG_COUNT; r++) begin
         cnt_nxt = cnt_nxt + {{(CW-1){1'b0}}, pend_nxt[r]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs       <= '0;
         pend       <= '0;
         busy_cnt_o <= '0;
      end else begin
         // Later loop iterations override earlier ones: highest port wins.
         for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && (wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
               regs[wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         pend       <= pend_nxt;
         busy_cnt_o <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst_n;
   logic [1:0]    we;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;
   logic [2*AW-1:0] rd_addr;
   logic [2*DW-1:0] rd_data;
   logic [1:0]    rd_ready;
   logic          iss_valid;
   logic [AW-1:0] iss_rd;
   logic          flush;
   logic [5:0]    busy_cnt;

   int n_pass;
   int n_total;

   regfile_scoreboard dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (we),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_ready_o (rd_ready),
      .iss_valid_i(iss_valid),
      .iss_rd_i   (iss_rd),
      .flush_i    (flush),
      .busy_cnt_o (busy_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we        = '0;
      wr_addr   = '0;
      wr_data   = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
      flush     = 1'b0;
   endtask

   task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[k]                 = 1'b1;
      wr_addr[k*AW +: AW]   = a;
      wr_data[k*DW +: DW]   = d;
   endtask

   task automatic rd(input int j, input logic [AW-1:0] a);
      rd_addr[j*AW +: AW] = a;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      rd_addr = '0;
      idle();
      #12;
      chk("reset_busy", 64'(busy_cnt), 64'd0);
      rst_n = 1'b1;
      tick();

      // Fresh register file: x5 and x0 read zero and ready
      rd(0, 5); rd(1, 0);
      #1;
      chk("x5_data", 64'(rd_data[31:0]), 64'd0);
      chk("x5_ready", 64'(rd_ready[0]), 64'd1);
      chk("x0_data", 64'(rd_data[63:32]), 64'd0);
      chk("x0_ready", 64'(rd_ready[1]), 64'd1);
      chk("busy_idle", 64'(busy_cnt), 64'd0);

      // Issue x3, then writeback through bypass
      iss_valid = 1'b1; iss_rd = 3;
      tick();
      idle();
      rd(0, 3); rd(1, 3);
      #1;
      chk("x3_pending_ready", 64'(rd_ready[0]), 64'd0);
      chk("x3_busy1", 64'(busy_cnt), 64'd1);
      wr(0, 3, 32'hDEADBEEF);
      #1;
      chk("x3_byp_ready", 64'(rd_ready[0]), 64'd1);
      chk("x3_byp_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
      chk("x3_byp_data_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
      tick();
      idle();
      #1;
      chk("x3_busy0", 64'(busy_cnt), 64'd0);
      chk("x3_stored", 64'(rd_data[31:0]), 64'hDEADBEEF);
      chk("x3_ready_after", 64'(rd_ready[0]), 64'd1);

      // Same-address double write: port 1 wins
      wr(0, 7, 32'h11); wr(1, 7, 32'h22);
      rd(0, 7);
      #1;
      chk("x7_byp", 64'(rd_data[31:0]), 64'h22);
      tick();
      idle();
      #1;
      chk("x7_stored", 64'(rd_data[31:0]), 64'h22);

      // Issue and write x4 together: stays pending with new data stored
      iss_valid = 1'b1; iss_rd = 4;
      wr(0, 4, 32'h55);
      tick();
      idle();
      rd(0, 4);
      #1;
      chk("x4_ready", 64'(rd_ready[0]), 64'd0);
      chk("x4_data", 64'(rd_data[31:0]), 64'h55);
      chk("x4_busy", 64'(busy_cnt), 64'd1);

      // Non-pending write leaves scoreboard alone
      wr(1, 10, 32'hA5);
      tick();
      idle();
      #1;
      chk("nonpend_wr_busy", 64'(busy_cnt), 64'd1);

      // Issue x1, x2, x9 then flush with issue x6
      iss_valid = 1'b1; iss_rd = 1;
      tick();
      iss_rd = 2;
      tick();
      iss_rd = 9;
      tick();
      idle();
      #1;
      chk("busy4", 64'(busy_cnt), 64'd4);
      flush = 1'b1; iss_valid = 1'b1; iss_rd = 6;
      tick();
      idle();
      rd(0, 6); rd(1, 1);
      #1;
      chk("flush_busy", 64'(busy_cnt), 64'd1);
      chk("flush_x6_ready", 64'(rd_ready[0]), 64'd0);
      chk("flush_x1_ready", 64'(rd_ready[1]), 64'd1);
      rd(1, 4);
      #1;
      chk("flush_x4_ready", 64'(rd_ready[1]), 64'd1);

      // x0 write + issue is ignored
      wr(0, 0, 32'hFFFF); iss_valid = 1'b1; iss_rd = 0;
      rd(0, 0);
      #1;
      chk("x0_wr_byp", 64'(rd_data[31:0]), 64'd0);
      tick();
      idle();
      #1;
      chk("x0_data_after", 64'(rd_data[31:0]), 64'd0);
      chk("x0_ready_after", 64'(rd_ready[0]), 64'd1);
      chk("x0_busy_same", 64'(busy_cnt), 64'd1);

      // Asynchronous reset mid-cycle clears everything at once
      rd(0, 3); rd(1, 6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_busy", 64'(busy_cnt), 64'd0);
      chk("areset_x3", 64'(rd_data[31:0]), 64'd0);
      chk("areset_x6_ready", 64'(rd_ready[1]), 64'd1);

      // Writes and issues presented during reset are discarded
      wr(0, 5, 32'hAB); iss_valid = 1'b1; iss_rd = 5;
      tick();
      idle();
      rst_n = 1'b1;
      rd(0, 5);
      #1;
      chk("rst_discard_x5", 64'(rd_data[31:0]), 64'd0);
      chk("rst_discard_busy", 64'(busy_cnt), 64'd0);

      // First edge after reset does normal work
      wr(0, 5, 32'h77); iss_valid = 1'b1; iss_rd = 8;
      tick();
      idle();
      #1;
      chk("post_rst_x5", 64'(rd_data[31:0]), 64'h77);
      chk("post_rst_busy", 64'(busy_cnt), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register data width.
REQ-002 Parameter REG_COUNT, default 32: number of architectural registers.
REQ-003 Parameter ADDR_WIDTH, default $clog2(REG_COUNT): register address width.
REQ-004 Parameter NUM_RD, default 2: number of read ports.
REQ-005 Parameter NUM_WR, default 2: number of write ports.
REQ-006 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port we_i, input, NUM_WR: per-write-port enable.
REQ-009 Port wr_addr_i, input, NUM_WR*ADDR_WIDTH: packed write addresses; port k occupies slice k.
REQ-010 Port wr_data_i, input, NUM_WR*DATA_WIDTH: packed write data.
REQ-011 Port rd_addr_i, input, NUM_RD*ADDR_WIDTH: packed read addresses.
REQ-012 Port rd_data_o, output, NUM_RD*DATA_WIDTH: packed read data, combinational.
REQ-013 Port rd_ready_o, output, NUM_RD: operand-valid flag per read port, combinational.
REQ-014 Port iss_valid_i, input, 1: issue strobe; reserves a destination register.
REQ-015 Port iss_rd_i, input, ADDR_WIDTH: destination register being reserved.
REQ-016 Port flush_i, input, 1: clears all reservations.
REQ-017 Port busy_cnt_o, output, $clog2(REG_COUNT+1): registered count of pending registers.

Function
REQ-018 Register 0 SHALL never be written, never pending, and SHALL always read 0 with ready=1.
REQ-019 Write port k with we_i[k]=1 and address!=0 SHALL update that register at the next posedge.
REQ-020 Same address written by two ports in one cycle: the highest-index port wins, for both the storage update and the bypass.
REQ-021 Read port j SHALL return the same-cycle write data when an enabled write (address!=0) matches rd_addr_j; the winning port is chosen per REQ-020.
REQ-022 Read port j without a bypass match SHALL return stored contents.
REQ-023 Each register r>0 SHALL have a pending bit.
REQ-024 A pending bit SHALL be set at posedge when iss_valid_i=1 and iss_rd_i=r!=0.
REQ-025 A pending bit SHALL be cleared at posedge when any enabled write targets r.
REQ-026 Issue and write to the same r in one cycle: set wins, and r stays pending (new producer).
REQ-027 flush_i=1 SHALL clear all pending bits at posedge; an issue in the same cycle is applied after the flush, so only iss_rd_i is pending afterwards.
REQ-028 rd_ready_o[j] SHALL be 1 iff rd_addr_j=0, or its pending bit is 0, or a same-cycle bypass match exists.
REQ-029 Writes to non-pending registers SHALL be legal and have no effect on the scoreboard.
REQ-030 busy_cnt_o SHALL equal the number of set pending bits, updated in the same posedge as the bits, with no wrap.

Reset
REQ-031 While rst_n=0, all registers, all pending bits and busy_cnt_o SHALL be 0 immediately, independent of clk.
REQ-032 A reset asserted mid-operation SHALL discard same-cycle writes and issues.
REQ-033 After rst_n deasserts, the first posedge SHALL perform normal updates.

Verification
REQ-034 Reset, then read x5 and x0 -> data 0, ready 1, busy_cnt_o=0.
REQ-035 Issue x3; next cycle read x3 -> ready 0, busy_cnt_o=1; write x3=0xDEADBEEF on port 0 -> same cycle ready 1, data 0xDEADBEEF; next cycle busy_cnt_o=0.
REQ-036 Port 0 writes x7=0x11 and port 1 writes x7=0x22 in the same cycle -> bypass 0x22; stored value 0x22.
REQ-037 Issue x4 while writing x4=0x55 -> x4 pending next cycle, stored 0x55, ready 0.
REQ-038 Issue x1, x2, x9 on successive cycles, then flush_i together with issue x6 -> only x6 pending, busy_cnt_o=1.
REQ-039 Write x0=0xFFFF with issue x0 -> x0 reads 0, ready 1, busy_cnt_o unchanged; rst_n pulsed low between clock edges -> outputs cleared immediately.
